// File: rtl/pipe_ctrl_gen_if.sv
// Decoder-to-control-pipeline instruction handshake bundle.
// No storage; carries one decoded instruction per cycle.
// Backpressure via id_ready driven by the pipeline (slave) side.
interface pipe_ctrl_gen_if #(
    parameter int CWW = 18,
    parameter int RW  = 3
);
    logic           id_valid;
    logic           id_ready;
    logic [CWW-1:0] id_cw;
    logic           id_cond;
    logic           id_fl;
    logic           id_br;
    logic           id_load;
    logic [RW-1:0]  id_dst;
    logic [RW-1:0]  id_src;
    logic           id_uses_src;

    modport master (
        output id_valid, id_cw, id_cond, id_fl, id_br, id_load,
               id_dst, id_src, id_uses_src,
        input  id_ready
    );

    modport slave (
        input  id_valid, id_cw, id_cond, id_fl, id_br, id_load,
               id_dst, id_src, id_uses_src,
        output id_ready
    );
endinterface

// File: rtl/pipe_ctrl_gen.sv
// Control-word pipeline: issue/flag stage, conditional annul, load-use stall, branch-shadow squash.
// Latency DEPTH cycles from accept to cw_out; flush_out and id_ready are combinational.
// Backpressure: id_ready drops on hold or on a load-use hazard; squashed words are consumed, never stalled.
module pipe_ctrl_gen #(
    parameter int CWW    = 18,
    parameter int DEPTH  = 3,
    parameter int RW     = 3,
    parameter int SHADOW = 1,
    parameter int CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_ctrl_gen_if.slave    dec,
    input  logic              hold,
    output logic [CWW-1:0]    cw_out,
    output logic              valid_out,
    output logic              flush_out,
    output logic [CNTW-1:0]   bubble_cnt
);
    localparam logic [2:0]      SQ_LOAD = 3'(SHADOW - 1);
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    // Stage 1 (issue/flag stage) fields
    logic           v1;
    logic [CWW-1:0] cw1;
    logic           cond1;
    logic           fl1;
    logic           br1;
    logic           load1;
    logic [RW-1:0]  dst1;

    // Stages 2..DEPTH carry only the resolved control word
    logic [DEPTH:2] v_q;
    logic [CWW-1:0] cw_q [2:DEPTH];

    logic [2:0] sq_cnt;

    logic exec1;
    logic taken1;
    logic squash;
    logic hazard;
    logic accept;
    logic bubble_inc;

    // Condition resolution, squash window, load-use hazard and handshake
    always_comb begin
        exec1      = v1 & (~cond1 | fl1);
        taken1     = exec1 & br1;
        squash     = taken1 | (sq_cnt != 3'd0);
        hazard     = exec1 & load1 & dec.id_valid & dec.id_uses_src & (dec.id_src == dst1);
        // squash dominates hazard: a word in the branch shadow is dropped, not stalled
        dec.id_ready = ~hold & (squash | ~hazard);
        accept     = dec.id_valid & dec.id_ready & ~squash;
        bubble_inc = ~hold & (hazard | (squash & dec.id_valid));
        flush_out  = taken1 & ~hold;
    end

    // Stage 1 capture: accepted instruction or an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            cw1   <= '0;
            cond1 <= 1'b0;
            fl1   <= 1'b0;
            br1   <= 1'b0;
            load1 <= 1'b0;
            dst1  <= '0;
        end else if (!hold) begin
            if (accept) begin
                v1    <= 1'b1;
                cw1   <= dec.id_cw;
                cond1 <= dec.id_cond;
                fl1   <= dec.id_fl;
                br1   <= dec.id_br;
                load1 <= dec.id_load;
                dst1  <= dec.id_dst;
            end else begin
                v1    <= 1'b0;
                cw1   <= '0;
                cond1 <= 1'b0;
                fl1   <= 1'b0;
                br1   <= 1'b0;
                load1 <= 1'b0;
                dst1  <= '0;
            end
        end
    end

    // Stages 2..DEPTH: annulled conditionals leave stage 1 as a zero word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int k = 2; k <= DEPTH; k++) cw_q[k] <= '0;
        end else if (!hold) begin
            v_q[2]  <= exec1;
            cw_q[2] <= exec1 ? cw1 : '0;
            for (int k = 3; k <= DEPTH; k++) begin
                v_q[k]  <= v_q[k-1];
                cw_q[k] <= cw_q[k-1];
            end
        end
    end

    // Branch-shadow counter: reloads on a taken branch, drains otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_cnt <= 3'd0;
        end else if (!hold) begin
            if (taken1)
                sq_cnt <= SQ_LOAD;
            else if (sq_cnt != 3'd0)
                sq_cnt <= sq_cnt - 3'd1;
        end
    end

    // Saturating count of bubbles forced by hazard or squash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (bubble_inc && bubble_cnt != CNT_MAX)
            bubble_cnt <= bubble_cnt + CNT_ONE;
    end

    assign cw_out    = cw_q[DEPTH];
    assign valid_out = v_q[DEPTH];
endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Directed bench for pipe_ctrl_gen with DEPTH=3, SHADOW=2, CNTW=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values are hand-derived constants per scenario.
module tb_pipe_ctrl_gen;
    localparam int CWW = 18;
    localparam int RW  = 3;

    logic            clk;
    logic            rst_n;
    logic            hold;
    logic [CWW-1:0]  cw_out;
    logic            valid_out;
    logic            flush_out;
    logic [3:0]      bubble_cnt;

    int n_checks;
    int n_fail;

    pipe_ctrl_gen_if #(.CWW(CWW), .RW(RW)) dec ();

    pipe_ctrl_gen #(
        .CWW(CWW), .DEPTH(3), .RW(RW), .SHADOW(2), .CNTW(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dec        (dec.slave),
        .hold       (hold),
        .cw_out     (cw_out),
        .valid_out  (valid_out),
        .flush_out  (flush_out),
        .bubble_cnt (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CWW-1:0] cw, input logic cond,
                         input logic fl, input logic br, input logic ld,
                         input logic [RW-1:0] dst, input logic [RW-1:0] src,
                         input logic uses);
        dec.id_valid    = v;
        dec.id_cw       = cw;
        dec.id_cond     = cond;
        dec.id_fl       = fl;
        dec.id_br       = br;
        dec.id_load     = ld;
        dec.id_dst      = dst;
        dec.id_src      = src;
        dec.id_uses_src = uses;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic plain(input logic [CWW-1:0] cw);
        drive(1'b1, cw, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        hold     = 1'b0;
        idle();

        // 1. reset state, then one plain instruction through the pipe
        #12;
        check("rst_cw_out",    32'(cw_out), 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_flush_out", 32'(flush_out), 32'h0);
        check("rst_bubble",    32'(bubble_cnt), 32'h0);
        rst_n = 1'b1;
        plain(18'h00C01);
        #1;
        check("t1_ready", 32'(dec.id_ready), 32'h1);
        tick();
        idle();
        tick();
        check("t1_not_yet", 32'(valid_out), 32'h0);
        tick();
        check("t1_cw_out",    32'(cw_out), 32'h00C01);
        check("t1_valid_out", 32'(valid_out), 32'h1);
        tick();
        check("t1_drained", 32'(valid_out), 32'h0);

        // 2. conditional annulled, then executed
        drive(1'b1, 18'h20001, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        check("t2_annul_valid", 32'(valid_out), 32'h0);
        check("t2_annul_cw",    32'(cw_out), 32'h0);
        drive(1'b1, 18'h20001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        check("t2_exec_valid", 32'(valid_out), 32'h1);
        check("t2_exec_cw",    32'(cw_out), 32'h20001);
        tick();

        // 3. load-use stall on src==dst, none on src!=dst
        drive(1'b1, 18'h08010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0);
        tick();
        drive(1'b1, 18'h00205, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd2, 1'b1);
        #1;
        check("t3_stall_ready", 32'(dec.id_ready), 32'h0);
        tick();
        check("t3_resume_ready", 32'(dec.id_ready), 32'h1);
        check("t3_bubble_1",     32'(bubble_cnt), 32'h1);
        tick();
        idle();
        check("t3_lda_out", 32'(cw_out), 32'h08010);
        tick();
        check("t3_bubble_out", 32'(valid_out), 32'h0);
        tick();
        check("t3_dep_out",   32'(cw_out), 32'h00205);
        check("t3_dep_valid", 32'(valid_out), 32'h1);
        drive(1'b1, 18'h08010, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0);
        tick();
        drive(1'b1, 18'h00306, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 3'd3, 1'b1);
        #1;
        check("t3_nostall_ready", 32'(dec.id_ready), 32'h1);
        tick();
        idle();
        tick();
        check("t3_lda2_out", 32'(cw_out), 32'h08010);
        tick();
        check("t3_b2b_out",  32'(cw_out), 32'h00306);
        check("t3_bubble_still_1", 32'(bubble_cnt), 32'h1);
        tick();
        tick();

        // 4a. branch whose condition fails does not flush
        drive(1'b1, 18'h00080, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        idle();
        #1;
        check("t4_ncbr_flush", 32'(flush_out), 32'h0);
        tick();
        tick();
        tick();

        // 4b. taken branch discards the next two words of a continuous stream
        drive(1'b1, 18'h00080, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        plain(18'h00111);
        #1;
        check("t4_flush",     32'(flush_out), 32'h1);
        check("t4_sq1_ready", 32'(dec.id_ready), 32'h1);
        tick();
        plain(18'h00222);
        #1;
        check("t4_flush_once", 32'(flush_out), 32'h0);
        check("t4_sq2_ready",  32'(dec.id_ready), 32'h1);
        tick();
        check("t4_br_out", 32'(cw_out), 32'h00080);
        plain(18'h00333);
        tick();
        idle();
        check("t4_shadow1_out", 32'(valid_out), 32'h0);
        tick();
        check("t4_shadow2_out", 32'(valid_out), 32'h0);
        tick();
        check("t4_third_out", 32'(cw_out), 32'h00333);
        check("t4_bubble_3",  32'(bubble_cnt), 32'h3);
        tick();
        tick();

        // 5. hold for four cycles with a taken branch sitting in stage 1
        plain(18'h00A01);
        tick();
        plain(18'h00A02);
        tick();
        drive(1'b1, 18'h00A80, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
        tick();
        plain(18'h00A03);
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_hold_ready",  32'(dec.id_ready), 32'h0);
            check("t5_hold_flush",  32'(flush_out), 32'h0);
            check("t5_hold_cw",     32'(cw_out), 32'h00A01);
            check("t5_hold_valid",  32'(valid_out), 32'h1);
            check("t5_hold_bubble", 32'(bubble_cnt), 32'h3);
            tick();
        end
        hold = 1'b0;
        #1;
        check("t5_rel_flush", 32'(flush_out), 32'h1);
        check("t5_rel_ready", 32'(dec.id_ready), 32'h1);
        tick();
        check("t5_p1_out", 32'(cw_out), 32'h00A02);
        plain(18'h00A04);
        tick();
        check("t5_br_out", 32'(cw_out), 32'h00A80);
        plain(18'h00A05);
        tick();
        idle();
        check("t5_sq1_out", 32'(valid_out), 32'h0);
        tick();
        check("t5_sq2_out", 32'(valid_out), 32'h0);
        tick();
        check("t5_next_out", 32'(cw_out), 32'h00A05);
        check("t5_bubble_5", 32'(bubble_cnt), 32'h5);
        tick();
        tick();

        // 6. self-dependent loads: one hazard bubble every other cycle, 20 in total
        drive(1'b1, 18'h04001, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 3'd1, 1'b1);
        for (int i = 0; i < 40; i++) tick();
        check("t6_saturated", 32'(bubble_cnt), 32'hF);
        plain(18'h12345);
        tick();
        idle();
        tick();
        tick();
        check("t6_pre_rst_cw",    32'(cw_out), 32'h12345);
        check("t6_pre_rst_valid", 32'(valid_out), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_arst_cw",     32'(cw_out), 32'h0);
        check("t6_arst_valid",  32'(valid_out), 32'h0);
        check("t6_arst_flush",  32'(flush_out), 32'h0);
        check("t6_arst_bubble", 32'(bubble_cnt), 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_post_valid",  32'(valid_out), 32'h0);
        check("t6_post_bubble", 32'(bubble_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
